// File: rtl/fwd_scoreboard.sv
// Purpose : operand-forwarding scoreboard beside decode; tracks {valid, rd, regwrite, memread}
//           of every in-flight instruction for DEPTH post-decode stages and picks a forward
//           source per decode operand, raising a load-use stall when a load is too young.
// Latency : fwd_sel / load_use_stall are combinational (0 cycles); stage entries advance on
//           each rising clk edge, so an instruction issued in cycle t sits at stage k in t+k.
// Backpressure: hold freezes every stage; load_use_stall inserts a bubble at stage 1 while
//           decode re-presents the same instruction.
//
// Ports:
//   clk, reset (async, active-low)
//   issue_valid/issue_rd/issue_regwrite/issue_memread : the instruction currently in decode
//   src_reg/src_en : NUM_SRC decode operands, operand i at src_reg[i*REG_W +: REG_W]
//   hold   : downstream stall, all stages keep their contents
//   flush  : squash the decode instruction (bubble into stage 1, or clear stage 1 under hold)
//   fwd_sel: per operand, SEL_W bits: 0 = register file, k = forward from stage k
//   load_use_stall : decode must hold this cycle
//
// Build option: define FWD_XZR_FILTER_EN to stop register 31 (XZR) from ever matching.

module fwd_scoreboard #(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [REG_W-1:0]           issue_rd,
  input  logic                       issue_regwrite,
  input  logic                       issue_memread,
  input  logic [NUM_SRC*REG_W-1:0]   src_reg,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic                       hold,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       load_use_stall
);

  // One tracked pipeline slot.
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } entry_t;

  localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_STAGE);

  // Array index 0 is stage 1 (EX, youngest); index DEPTH-1 is stage DEPTH (WB, oldest).
  entry_t stage_q [DEPTH];
  entry_t stage_d [DEPTH];

  logic [SEL_W-1:0]   sel      [NUM_SRC];
  logic [NUM_SRC-1:0] win_load;
  logic [NUM_SRC-1:0] hazard;
  logic               issue_live;

  // A slot produces a value for operand 'r' only if it is live, writes the register
  // file and targets the same register.
  function automatic logic entry_match(input entry_t e, input logic [REG_W-1:0] r);
    logic m;
    m = e.vld & e.regwrite & (e.rd == r);
`ifdef FWD_XZR_FILTER_EN
    // XZR reads as zero regardless of any in-flight write to it.
    m = m & (r != {REG_W{1'b1}});
`endif
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand lookup: scan oldest to youngest so the youngest match overwrites and wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_load = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (src_en[i] && entry_match(stage_q[k], src_reg[i*REG_W +: REG_W])) begin
          sel[i]      = SEL_W'(k + 1);
          win_load[i] = stage_q[k].memread;
        end
      end
    end
  end

  // A hazard exists only when the winning producer is a load that has not yet reached
  // the stage where its data becomes available.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hazard[i] = (sel[i] != '0) && (sel[i] < LOAD_SEL) && win_load[i];
    end
  end

  // A flushed decode slot never stalls: it is about to disappear anyway.
  assign issue_live     = issue_valid & ~flush;
  assign load_use_stall = issue_live & (|hazard);

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i*SEL_W +: SEL_W] = sel[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage shift register next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (hold) begin
      // Frozen pipeline; a flush can still kill the youngest tracked instruction.
      if (flush) begin
        stage_d[0].vld = 1'b0;
      end
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        stage_d[k] = stage_q[k-1];
      end
      // On a load-use stall the decode instruction stays in decode, so a bubble enters.
      stage_d[0].vld      = issue_live & ~load_use_stall;
      stage_d[0].rd       = issue_rd;
      stage_d[0].regwrite = issue_regwrite;
      stage_d[0].memread  = issue_memread;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding scoreboard for the pipelined CPU. Tracks the destination register, write-enable and load flag of every in-flight instruction across `DEPTH` post-decode pipeline stages in its own shift register. Each cycle it produces a forward-select code for each of `NUM_SRC` decode-stage source operands (ALU operands and the CBZ test register alike), plus a load-use stall. It sits beside the decode stage and replaces per-operand ad-hoc comparators.

## Interface
- `REG_W`, 5, register-index width
- `DEPTH`, 3, tracked stages after decode (stage 1 = youngest, EX; stage `DEPTH` = oldest, WB)
- `NUM_SRC`, 2, number of source operands queried per cycle
- `LOAD_STAGE`, 2, first stage at which a load's result is forwardable (1 ≤ `LOAD_STAGE` ≤ `DEPTH`)
- `SEL_W` (derived), `$clog2(DEPTH+1)`

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  decode holds a real instruction
- `issue_rd`  in  `REG_W`  its destination
- `issue_regwrite`  in  1  it writes the register file
- `issue_memread`  in  1  it is a load
- `src_reg`  in  `NUM_SRC*REG_W`  source indices, operand i at bits [i*REG_W +: REG_W]
- `src_en`  in  `NUM_SRC`  operand i is actually read
- `hold`  in  1  freeze all tracked stages (downstream stall)
- `flush`  in  1  squash the decode instruction
- `fwd_sel`  out  `NUM_SRC*SEL_W`  per operand: 0 = register file, k = forward from stage k
- `load_use_stall`  out  1  decode must hold; a bubble enters stage 1

## Operation
- Each stage entry holds {valid, rd, regwrite, memread}. Reset clears all valid bits, so `fwd_sel` = 0 and `load_use_stall` = 0 under reset.
- Match for operand i at stage k: `src_en[i]` & valid_k & regwrite_k & (rd_k == `src_reg[i]`).
- `fwd_sel[i]` = smallest k that matches (the youngest producer wins), else 0.
- Hazard for operand i: the winning stage k < `LOAD_STAGE` and memread_k = 1.
- `load_use_stall` = `issue_valid` & ~`flush` & (any operand hazard). When stalled, `fwd_sel` still reports the winning stage; consumers ignore it.
- Shift update:
  - `hold` = 0:
    - stage k ← stage k−1 for k ≥ 2.
    - stage 1 ← issue entry, with valid = `issue_valid` & ~`flush` & ~`load_use_stall`.
    - The oldest entry retires.
  - `hold` = 1:
    - all stages retain their contents.
    - If `flush` = 1 in the same cycle, stage 1 valid is cleared; other stages are unaffected.
- `flush` without `hold` inserts a bubble into stage 1. `load_use_stall` is forced to 0 that cycle.
- `issue_regwrite` = 0 entries are still shifted, but they never match.

## Timing
- `fwd_sel` and `load_use_stall` are combinational from the current inputs and the registered stages: zero-cycle latency, valid in the same cycle as `src_reg`.
- The stage register updates on the rising edge. An instruction issued in cycle t is visible at stage k in cycle t+k, when no `hold` is applied.
- Asynchronous reset mid-operation clears every entry immediately. Outputs go to 0 without waiting for a clock edge.
- A load hazard clears after (`LOAD_STAGE` − k) stalled cycles, because the load keeps advancing while decode holds.

## Configuration
- `FWD_XZR_FILTER_EN`:
  - Defined: index 31 (all ones, XZR) never matches. `fwd_sel` = 0 and no stall results for an operand naming X31.
  - Undefined: X31 is compared like any other register.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream with 3 valid entries in flight → all `fwd_sel` = 0 and `load_use_stall` = 0 immediately; the entries are gone after release.
- **Priority:** issue X5 writes in cycles 0 and 1, then query `src_reg[0]` = 5 in cycle 2 → `fwd_sel[0]` = 1 (not 2). Query again in cycle 3 → 2.
- **Load-use:** issue a load to X3, then query `src_reg[1]` = 3 in the next cycle → `load_use_stall` = 1 for exactly one cycle. The following cycle gives `fwd_sel[1]` = 2 and stall = 0, and stage 1 holds a bubble.
- **Disabled operands and non-writers:** `src_en` = 0, or a match only against an entry with `regwrite` = 0 → `fwd_sel` = 0.
- **Hold/flush interplay:**
  - `hold` = 1 for 2 cycles → `fwd_sel` for a matching operand is constant.
  - `hold` + `flush` → the stage 1 match vanishes next cycle; stage 2 is unchanged.
- **XZR:** X31 producer with `src_reg` = 31 → `fwd_sel` = 0 with `FWD_XZR_FILTER_EN` defined, and 1 without it.
